p_wqe_rd_ctrl: RTL and testbench
================================

# p_wqe_rd_ctrl

Read-side controller for the pending-WQE dual-port SRAM. The writer commits WQEs through RAM port A and publishes its write pointer. This block fetches committed entries through RAM port B and streams them out on a valid/ready interface in order. It returns the consumed-entry pointer to the writer so freed slots can be reused. It absorbs the RAM read latency with a small skid buffer, so the output sustains one WQE per cycle.

## Interface
- WIDTH_ADDR, 8: RAM address width; ring depth is 2^WIDTH_ADDR entries.
- WIDTH_DATA, 8: WQE word width; must equal the RAM data width.
- DOUT_REG, "false": must match the RAM's port-B DOUT_REG. "false" gives RAM read latency RD_LAT=1; "true" gives RD_LAT=2.
- clk  in  1  single clock; RAM port B is also on this clock.
- rst_n  in  1  synchronous reset, active-low.
- wr_ptr  in  WIDTH_ADDR+1  writer commit pointer; MSB is the wrap bit. Changes only after the RAM write for that entry has completed.
- rd_ptr  out  WIDTH_ADDR+1  consumed pointer returned to the writer (wrap bit in MSB).
- flush  in  1  discards all pending, in-flight and buffered WQEs.
- addrb  out  WIDTH_ADDR  RAM port-B address.
- renb  out  1  RAM port-B read enable.
- wenb  out  1  tied 0.
- dinb  out  WIDTH_DATA  tied 0.
- doutb  in  WIDTH_DATA  RAM port-B read data.
- wqe_valid  out  1  output WQE valid.
- wqe_ready  in  1  downstream accept.
- wqe_data  out  WIDTH_DATA  output WQE.
- wqe_cnt  out  32  delivered-WQE counter (see Configuration).

## Operation
- **Pointers.** All pointers are WIDTH_ADDR+1 bits; arithmetic is modulo 2^(WIDTH_ADDR+1).
  - wr_ptr_q: wr_ptr registered once.
  - fetch_ptr: next address to read.
  - rd_ptr: next entry to be consumed.
- **Available.** fetch_ptr != wr_ptr_q.
- **Skid buffer.** FIFO of DEPTH = RD_LAT+2 entries, with a count.
- **In-flight tracking.** An RD_LAT-stage valid shift register tracks issued reads. inflight = number of set bits.
- **Issue condition.** Issue when available, !flush, and (inflight + count − pop) < DEPTH, where pop = wqe_valid & wqe_ready.
- **On issue.**
  - renb=1 and addrb=fetch_ptr[WIDTH_ADDR-1:0].
  - fetch_ptr increments.
  - A 1 enters the shift register.
- **Capture.** When the shift register's last stage is 1, doutb is pushed into the skid buffer that cycle.
- **Output.**
  - wqe_valid = (count != 0).
  - wqe_data = FIFO head.
  - wqe_valid holds with stable wqe_data until accepted.
- **Consume.** On pop, rd_ptr increments. rd_ptr never passes fetch_ptr.
- **Flush (cycle F).**
  - At the end of F: shift register cleared, skid buffer emptied, fetch_ptr ← wr_ptr_q, rd_ptr ← wr_ptr_q.
  - No issue and no pop in cycle F; wqe_valid still reflects the pre-flush count, but wqe_ready is ignored.
  - wr_ptr_q still updates in F.
- **Wrap-around.** Address wraps to 0 after 2^WIDTH_ADDR−1; the wrap bit toggles.
- **Full ring.** rd_ptr vs wr_ptr distance reaching 2^WIDTH_ADDR is the writer's concern. This block never reads beyond wr_ptr_q.
- **Reset values.** rd_ptr=0, fetch_ptr=0, wr_ptr_q=0, renb=0, addrb=0, wqe_valid=0, wqe_data=0, wqe_cnt=0, skid count=0, shift register=0.
- **Reset mid-operation.** Everything above is discarded at the same time, with no partial output.

## Timing
- **Latency.** wr_ptr advances in cycle N:
  - renb=1 in N+1.
  - Capture at the end of N+1+RD_LAT.
  - wqe_valid=1 in N+2+RD_LAT: N+3 when DOUT_REG="false", N+4 when "true".
- **Throughput.** With wqe_ready held high and entries available, one WQE per cycle indefinitely.
- **Back-pressure.** With wqe_ready=0, issue stops once inflight+count reaches DEPTH. No captured data is ever dropped.
- **Ready rises again.** The first pop happens in the same cycle. Issue resumes in the same cycle via the −pop term.
- **rd_ptr visibility.** Updated the cycle after the pop handshake.
- **Simultaneous events.**
  - Capture and pop in the same cycle: count unchanged, head advances.
  - Flush together with reset: reset dominates.

## Configuration
- **P_WQE_RD_CNT_EN defined:** wqe_cnt increments by 1 on every pop. It wraps at 2^32. It is cleared only by reset; flush does not clear it.
- **P_WQE_RD_CNT_EN undefined:** no counter register; wqe_cnt tied 0.

## Test plan
- **Single WQE, DOUT_REG="false".** After reset, RAM[0]=0xA5; wr_ptr 0→1 in cycle 10 → renb=1 with addrb=0 in cycle 11; wqe_valid=1 with wqe_data=0xA5 in cycle 13; rd_ptr=1 the cycle after accept.
- **Streaming.** 20 entries committed at once, wqe_ready=1 → 20 consecutive valid cycles, data in address order; wqe_cnt=20 when P_WQE_RD_CNT_EN is defined, 0 otherwise.
- **Back-pressure.** 10 entries, wqe_ready=0 for 15 cycles → at most DEPTH reads issued (3 for RD_LAT=1, 4 for RD_LAT=2); wqe_data holds the first entry. Releasing ready → all 10 delivered in order with no gaps.
- **Wrap-around.** WIDTH_ADDR=3: push and consume 12 entries → addrb sequence 0..7,0..3; rd_ptr ends at 4'b1100.
- **Flush mid-stream.** 6 entries pending, 2 buffered, 1 in flight; flush for 1 cycle → wqe_valid=0 the next cycle, rd_ptr=fetch_ptr=wr_ptr_q, no stale data delivered afterwards.
- **Reset mid-stream.** rst_n=0 for 1 cycle with data buffered → all outputs at their reset values the next cycle.

Source files
------------

// File: rtl/p_wqe_rd_ctrl_if.sv
// WQE output stream: valid/ready handshake carrying one WQE word per beat.
// master = WQE source (the read controller), slave = downstream consumer.
interface p_wqe_rd_ctrl_if #(
    parameter int WIDTH_DATA = 8
);
    logic                  wqe_valid;
    logic                  wqe_ready;
    logic [WIDTH_DATA-1:0] wqe_data;

    modport master (output wqe_valid, output wqe_data, input wqe_ready);
    modport slave  (input wqe_valid, input wqe_data, output wqe_ready);
endinterface

// File: rtl/p_wqe_rd_ctrl.sv
// p_wqe_rd_ctrl: read-side controller for the pending-WQE dual-port SRAM.
// Fetches committed entries through RAM port B, absorbs the RAM read latency
// in a small skid FIFO and streams WQEs out in order, one per cycle.
// Optional feature: define P_WQE_RD_CNT_EN to build the delivered-WQE counter;
// when undefined wqe_cnt is tied to 0.
module p_wqe_rd_ctrl #(
    parameter int    WIDTH_ADDR = 8,
    parameter int    WIDTH_DATA = 8,
    parameter string DOUT_REG   = "false"
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_ADDR:0]   wr_ptr,
    output logic [WIDTH_ADDR:0]   rd_ptr,
    input  logic                  flush,
    output logic [WIDTH_ADDR-1:0] addrb,
    output logic                  renb,
    output logic                  wenb,
    output logic [WIDTH_DATA-1:0] dinb,
    input  logic [WIDTH_DATA-1:0] doutb,
    p_wqe_rd_ctrl_if.master       wqe,
    output logic [31:0]           wqe_cnt
);

    // RAM read latency follows the RAM's output-register setting.
    localparam int RD_LAT = (DOUT_REG == "true") ? 2 : 1;
    // One slot per in-flight read plus two so a full-rate stream never stalls.
    localparam int DEPTH  = RD_LAT + 2;
    localparam int IW     = $clog2(DEPTH);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int OW     = CW + 1;
    localparam int PW     = WIDTH_ADDR + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         fetch_ptr;
    logic [PW-1:0]         rd_ptr_q;
    logic [RD_LAT-1:0]     sr;
    logic [WIDTH_DATA-1:0] skid [DEPTH];
    logic [IW-1:0]         head;
    logic [IW-1:0]         tail;
    logic [CW-1:0]         count;

    logic                  valid;
    logic                  avail;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    logic [OW-1:0]         occ;

    // Advance a skid index, wrapping at DEPTH (not necessarily a power of two).
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + IW'(1);
    endfunction

    // Issue/pop decisions; a read may issue while the slot it needs frees this cycle.
    always_comb begin
        // NOTE: every always_comb output is assigned unconditionally up front, so no latch can be inferred.
        valid   = (count != '0);
        avail   = (fetch_ptr != wr_ptr_q);
        pop     = valid & wqe.wqe_ready & ~flush;
        capture = sr[RD_LAT-1];
        occ     = OW'($countones(sr)) + OW'(count);
        issue   = rst_n & avail & ~flush & (occ < OW'(DEPTH) + OW'(pop));
    end

    assign renb          = issue;
    assign addrb         = fetch_ptr[WIDTH_ADDR-1:0];
    assign wenb          = 1'b0;
    assign dinb          = '0;
    assign rd_ptr        = rd_ptr_q;
    assign wqe.wqe_valid = valid;
    assign wqe.wqe_data  = skid[head];

    // Pointer, in-flight and skid FIFO state; flush drops everything but the writer pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            fetch_ptr <= '0;
            rd_ptr_q  <= '0;
            sr        <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            // NOTE: the skid storage is reset because its head drives wqe_data directly, which must read 0 out of reset.
            for (int i = 0; i < DEPTH; i++) skid[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
            wr_ptr_q <= wr_ptr;
            if (flush) begin
                sr        <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                fetch_ptr <= wr_ptr_q;
                rd_ptr_q  <= wr_ptr_q;
            end else begin
                sr <= RD_LAT'({sr, issue});
                if (issue) fetch_ptr <= fetch_ptr + PTR_ONE;
                if (capture) begin
                    skid[tail] <= doutb;
                    tail       <= nxt(tail);
                end
                if (pop) begin
                    head     <= nxt(head);
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                count <= count + CW'(capture) - CW'(pop);
            end
        end
    end

`ifdef P_WQE_RD_CNT_EN
    logic [31:0] cnt_q;

    // Delivered-WQE counter; only reset clears it, it wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n)   cnt_q <= '0;
        else if (pop) cnt_q <= cnt_q + 32'd1;
    end

    assign wqe_cnt = cnt_q;
`else
    assign wqe_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_p_wqe_rd_ctrl.sv
// Directed self-checking bench for p_wqe_rd_ctrl (WIDTH_ADDR=8, WIDTH_DATA=8).
// A behavioural RAM returns exp_data(addr) with the configured read latency.
module tb_p_wqe_rd_ctrl;

    localparam string DOUT_REG = "false";
    localparam int    RD_LAT   = (DOUT_REG == "true") ? 2 : 1;
    localparam int    DEPTH    = RD_LAT + 2;

    logic       clk;
    logic       rst_n;
    logic [8:0] wr_ptr;
    logic [8:0] rd_ptr;
    logic       flush;
    logic [7:0] addrb;
    logic       renb;
    logic       wenb;
    logic [7:0] dinb;
    logic [7:0] doutb;
    logic [31:0] wqe_cnt;

    logic [7:0] mem [256];
    logic [7:0] ram_q1;
    logic [7:0] ram_q2;

    int n_errors = 0;
    int n_checks = 0;
    int n_rd;
    int exp_addr;
    int exp_d;

    p_wqe_rd_ctrl_if #(.WIDTH_DATA(8)) wqe_if ();

    p_wqe_rd_ctrl #(
        .WIDTH_ADDR (8),
        .WIDTH_DATA (8),
        .DOUT_REG   (DOUT_REG)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .flush   (flush),
        .addrb   (addrb),
        .renb    (renb),
        .wenb    (wenb),
        .dinb    (dinb),
        .doutb   (doutb),
        .wqe     (wqe_if),
        .wqe_cnt (wqe_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM port B model: registered read, optional output register.
    always @(posedge clk) if (renb) ram_q1 <= mem[addrb];
    always @(posedge clk) ram_q2 <= ram_q1;
    assign doutb = (RD_LAT == 2) ? ram_q2 : ram_q1;

    function automatic logic [7:0] exp_data(input int a);
        logic [7:0] b;
        b = a[7:0];
        return (b == 8'h00) ? 8'hA5 : (b ^ 8'h5A);
    endfunction

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef P_WQE_RD_CNT_EN
        return 32'(n);
`else
        return (n < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_ptr"}, 32'(rd_ptr), 32'd0);
        check({tag, "_renb"},   32'(renb), 32'd0);
        check({tag, "_addrb"},  32'(addrb), 32'd0);
        check({tag, "_valid"},  32'(wqe_if.wqe_valid), 32'd0);
        check({tag, "_data"},   32'(wqe_if.wqe_data), 32'd0);
        check({tag, "_cnt"},    wqe_cnt, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = exp_data(i);
        rst_n = 1'b0;
        flush = 1'b0;
        wr_ptr = 9'd0;
        wqe_if.wqe_ready = 1'b0;
        repeat (3) tick();
        tick(); rst_n = 1'b1; #1;
        check_reset("reset");
        check("reset_wenb", 32'(wenb), 32'd0);
        check("reset_dinb", 32'(dinb), 32'd0);

        // Single WQE: commit in N, read in N+1, valid in N+2+RD_LAT.
        tick(); wr_ptr = 9'd1; #1;
        check("t1_idle_renb", 32'(renb), 32'd0);
        tick(); #1;
        check("t1_renb", 32'(renb), 32'd1);
        check("t1_addrb", 32'(addrb), 32'd0);
        check("t1_early_valid", 32'(wqe_if.wqe_valid), 32'd0);
        repeat (RD_LAT) begin
            tick(); #1;
            check("t1_wait_valid", 32'(wqe_if.wqe_valid), 32'd0);
            check("t1_wait_renb", 32'(renb), 32'd0);
        end
        tick(); wqe_if.wqe_ready = 1'b1; #1;
        check("t1_valid", 32'(wqe_if.wqe_valid), 32'd1);
        check("t1_data", 32'(wqe_if.wqe_data), 32'h0A5);
        check("t1_rd_ptr_pre", 32'(rd_ptr), 32'd0);
        tick(); wqe_if.wqe_ready = 1'b0; #1;
        check("t1_rd_ptr", 32'(rd_ptr), 32'd1);
        check("t1_valid_after", 32'(wqe_if.wqe_valid), 32'd0);
        check("t1_cnt", wqe_cnt, cnt_exp(1));

        // Reset with flush asserted: reset dominates, counter cleared.
        tick(); rst_n = 1'b0; flush = 1'b1; wr_ptr = 9'd0;
        tick(); rst_n = 1'b1; flush = 1'b0; #1;
        check_reset("reset2");

        // Streaming: 20 entries, ready held high, one WQE per cycle.
        tick(); wr_ptr = 9'd20; wqe_if.wqe_ready = 1'b1;
        repeat (1 + RD_LAT) tick();
        for (int i = 0; i < 20; i++) begin
            tick(); #1;
            check("t2_valid", 32'(wqe_if.wqe_valid), 32'd1);
            check("t2_data", 32'(wqe_if.wqe_data), 32'(exp_data(i)));
        end
        tick(); #1;
        check("t2_valid_end", 32'(wqe_if.wqe_valid), 32'd0);
        check("t2_rd_ptr", 32'(rd_ptr), 32'd20);
        check("t2_cnt", wqe_cnt, cnt_exp(20));

        // Back-pressure: 10 entries, ready low for 15 cycles.
        tick(); wr_ptr = 9'd30; wqe_if.wqe_ready = 1'b0; #1;
        n_rd = int'(renb);
        repeat (14) begin
            tick(); #1;
            n_rd += int'(renb);
        end
        check("t3_reads_issued", 32'(n_rd), 32'(DEPTH));
        check("t3_hold_valid", 32'(wqe_if.wqe_valid), 32'd1);
        check("t3_hold_data", 32'(wqe_if.wqe_data), 32'(exp_data(20)));
        for (int i = 0; i < 10; i++) begin
            tick(); wqe_if.wqe_ready = 1'b1; #1;
            check("t3_valid", 32'(wqe_if.wqe_valid), 32'd1);
            check("t3_data", 32'(wqe_if.wqe_data), 32'(exp_data(20 + i)));
        end
        tick(); #1;
        check("t3_valid_end", 32'(wqe_if.wqe_valid), 32'd0);
        check("t3_rd_ptr", 32'(rd_ptr), 32'd30);

        // Wrap-around: 250 entries crossing address 255 -> 0 (wrap bit toggles).
        tick(); wr_ptr = 9'd280;
        exp_addr = 30;
        exp_d = 30;
        for (int c = 0; c < 300; c++) begin
            tick(); #1;
            if (renb) begin
                check("t4_addrb", 32'(addrb), 32'(exp_addr % 256));
                exp_addr++;
            end
            if (wqe_if.wqe_valid) begin
                check("t4_data", 32'(wqe_if.wqe_data), 32'(exp_data(exp_d)));
                exp_d++;
            end
        end
        check("t4_reads", 32'(exp_addr), 32'd280);
        check("t4_delivered", 32'(exp_d), 32'd280);
        check("t4_rd_ptr", 32'(rd_ptr), 32'h118);
        check("t4_valid_end", 32'(wqe_if.wqe_valid), 32'd0);

        // Flush with 2 buffered, RD_LAT in flight, 6 still pending.
        tick(); wr_ptr = 9'd289; wqe_if.wqe_ready = 1'b0;
        repeat (2 + RD_LAT) tick();
        tick(); flush = 1'b1; wqe_if.wqe_ready = 1'b1; #1;
        check("t5_f_valid", 32'(wqe_if.wqe_valid), 32'd1);
        check("t5_f_renb", 32'(renb), 32'd0);
        check("t5_f_data", 32'(wqe_if.wqe_data), 32'(exp_data(280)));
        tick(); flush = 1'b0; #1;
        check("t5_valid", 32'(wqe_if.wqe_valid), 32'd0);
        check("t5_rd_ptr", 32'(rd_ptr), 32'd289);
        check("t5_renb", 32'(renb), 32'd0);
        repeat (2 + RD_LAT) begin
            tick(); #1;
            check("t5_no_stale_valid", 32'(wqe_if.wqe_valid), 32'd0);
            check("t5_no_issue", 32'(renb), 32'd0);
        end
        check("t5_cnt", wqe_cnt, cnt_exp(280));

        // After flush only newly committed entries are delivered.
        tick(); wr_ptr = 9'd291;
        repeat (1 + RD_LAT) tick();
        tick(); #1;
        check("t5_new_valid0", 32'(wqe_if.wqe_valid), 32'd1);
        check("t5_new_data0", 32'(wqe_if.wqe_data), 32'(exp_data(289)));
        tick(); #1;
        check("t5_new_valid1", 32'(wqe_if.wqe_valid), 32'd1);
        check("t5_new_data1", 32'(wqe_if.wqe_data), 32'(exp_data(290)));
        tick(); #1;
        check("t5_new_end", 32'(wqe_if.wqe_valid), 32'd0);
        check("t5_new_rd_ptr", 32'(rd_ptr), 32'd291);
        check("t5_new_cnt", wqe_cnt, cnt_exp(282));

        // Reset mid-stream with data buffered.
        tick(); wr_ptr = 9'd296; wqe_if.wqe_ready = 1'b0;
        repeat (3 + RD_LAT) tick();
        #1;
        check("t6_buffered_valid", 32'(wqe_if.wqe_valid), 32'd1);
        check("t6_buffered_data", 32'(wqe_if.wqe_data), 32'(exp_data(291)));
        tick(); rst_n = 1'b0; wr_ptr = 9'd0;
        tick(); rst_n = 1'b1; #1;
        check_reset("t6_reset");
        tick(); #1;
        check("t6_quiet_valid", 32'(wqe_if.wqe_valid), 32'd0);
        check("t6_quiet_renb", 32'(renb), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
